// File: rtl/issue_scoreboard_pkg.sv
// Shared issue-stage defines: register file geometry, execution pipe ids and
// the default per-pipe write-back latencies.
package issue_scoreboard_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_WIDTH = $clog2(NUM_REGS);

  localparam int unsigned EXE_PIPE_ID_ALU = 0;
  localparam int unsigned EXE_PIPE_ID_LSU = 1;
  localparam int unsigned EXE_PIPE_ID_MUL = 2;
  localparam int unsigned EXE_PIPE_ID_DIV = 3;

  localparam logic [3:0] LAT_ALU = 4'd1;
  localparam logic [3:0] LAT_LSU = 4'd2;
  localparam logic [3:0] LAT_MUL = 4'd3;
  localparam logic [3:0] LAT_DIV = 4'd0;

  localparam logic [15:0] DEFAULT_PIPE_LAT = {LAT_DIV, LAT_MUL, LAT_LSU, LAT_ALU};

endpackage

// File: rtl/issue_scoreboard_wb_slot_tracker.sv
// Write-back slot reservation window: bit k set means the register write-back
// port is already claimed k+1 cycles from now.
module wb_slot_tracker #(
  parameter int unsigned MAX_LAT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_chk_lat,
  input  logic       i_set_en,
  input  logic [3:0] i_set_lat,
  output logic       o_conflict,
  output logic       o_resv_any
);

  logic [MAX_LAT-1:0] r_resv;
  logic [MAX_LAT-1:0] w_set;
  logic               w_conflict;

  // An op issued now with latency L owns slot L, which is L-1 ahead next cycle.
  always_comb begin
    w_conflict = 1'b0;
    w_set      = '0;
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      if (i_chk_lat == 4'(k + 1)) w_conflict = r_resv[k];
      if (i_set_en && (i_set_lat == 4'(k + 2))) w_set[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_resv <= '0;
    else        r_resv <= (r_resv >> 1) | w_set;
  end

  assign o_conflict = w_conflict;
  assign o_resv_any = |r_resv;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-control stage: decides each cycle whether the IQ head may fire, based
// on the register scoreboard, write-back slot reservations and variable pipes.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned             NUM_REGS     = issue_scoreboard_pkg::NUM_REGS,
  parameter int unsigned             REG_WIDTH    = $clog2(NUM_REGS),
  parameter int unsigned             NUM_PIPES    = 4,
  parameter logic [NUM_PIPES*4-1:0]  PIPE_LAT     = DEFAULT_PIPE_LAT,
  parameter int unsigned             MAX_LAT      = 8,
  parameter int unsigned             FLUSH_DEPTH  = 2,
  parameter bit                      VAR_BLOCKING = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hd_valid,
  input  logic [NUM_PIPES-1:0] hd_pipe,
  input  logic [REG_WIDTH-1:0] hd_rd,
  input  logic [REG_WIDTH-1:0] hd_rs1,
  input  logic [REG_WIDTH-1:0] hd_rs2,
  input  logic                 hd_reg_write,
  input  logic                 hd_uses_rs1,
  input  logic                 hd_uses_rs2,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic [NUM_PIPES-1:0] var_done,
  output logic                 issue_fire,
  output logic [NUM_PIPES-1:0] issue_pipe,
  output logic [NUM_REGS-1:0]  sb_busy,
  output logic                 idle
);

  typedef struct packed {
    logic                 valid;
    logic [REG_WIDTH-1:0] rd;
  } ring_entry_t;

  logic [NUM_REGS-1:0]  r_sb;
  logic [NUM_PIPES-1:0] r_var_busy;
  ring_entry_t          r_ring [FLUSH_DEPTH];

  logic [NUM_PIPES-1:0] w_var_mask;
  logic [3:0]           w_lat;
  logic                 w_nop;
  logic                 w_is_var;
  logic                 w_sb_haz;
  logic                 w_wb_haz;
  logic                 w_var_haz;
  logic                 w_fire;
  logic                 w_resv_conflict;
  logic                 w_resv_any;
  logic                 w_resv_set;
  logic [NUM_REGS-1:0]  w_sb_set;
  logic [NUM_REGS-1:0]  w_sb_clr;
  logic [NUM_REGS-1:0]  w_sb_nxt;

  always_comb begin
    w_var_mask = '0;
    w_lat      = '0;
    for (int unsigned p = 0; p < NUM_PIPES; p++) begin
      w_var_mask[p] = (PIPE_LAT[p*4 +: 4] == 4'd0);
      if (hd_pipe[p]) w_lat = w_lat | PIPE_LAT[p*4 +: 4];
    end
  end

  assign w_nop    = ~|hd_pipe;
  assign w_is_var = |(hd_pipe & w_var_mask);

  assign w_sb_haz = (hd_uses_rs1  && (hd_rs1 != '0) && r_sb[hd_rs1]) ||
                    (hd_uses_rs2  && (hd_rs2 != '0) && r_sb[hd_rs2]) ||
                    (hd_reg_write && (hd_rd  != '0) && r_sb[hd_rd]);
  assign w_wb_haz  = !w_is_var && hd_reg_write && w_resv_conflict;
  assign w_var_haz = (VAR_BLOCKING && (|r_var_busy)) || (|(hd_pipe & r_var_busy));

  assign w_fire = hd_valid && !flush && !hold &&
                  (w_nop || !(w_sb_haz || w_wb_haz || w_var_haz));

  assign w_resv_set = w_fire && !w_nop && !w_is_var && hd_reg_write;

  wb_slot_tracker #(
    .MAX_LAT (MAX_LAT)
  ) u_wb_slot_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_chk_lat  (w_lat),
    .i_set_en   (w_resv_set),
    .i_set_lat  (w_lat),
    .o_conflict (w_resv_conflict),
    .o_resv_any (w_resv_any)
  );

  // Set is applied after clear so a same-cycle re-issue to the written-back rd stays busy.
  always_comb begin
    w_sb_clr = '0;
    w_sb_set = '0;
    if (wb_valid) w_sb_clr[wb_rd] = 1'b1;
    if (flush) begin
      for (int unsigned i = 0; i < FLUSH_DEPTH; i++) begin
        if (r_ring[i].valid) w_sb_clr[r_ring[i].rd] = 1'b1;
      end
    end
    if (w_fire && !w_nop && hd_reg_write && (hd_rd != '0)) w_sb_set[hd_rd] = 1'b1;
    w_sb_nxt    = (r_sb & ~w_sb_clr) | w_sb_set;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb       <= '0;
      r_var_busy <= '0;
      for (int unsigned i = 0; i < FLUSH_DEPTH; i++) r_ring[i] <= '0;
    end else begin
      r_sb <= w_sb_nxt;
      if (flush) begin
        r_var_busy <= '0;
        for (int unsigned i = 0; i < FLUSH_DEPTH; i++) r_ring[i] <= '0;
      end else begin
        r_var_busy <= (r_var_busy & ~var_done) |
                      (hd_pipe & w_var_mask & {NUM_PIPES{w_fire}});
        if (w_fire && !w_nop) begin
          r_ring[0] <= '{valid: hd_reg_write && (hd_rd != '0), rd: hd_rd};
          for (int unsigned i = 1; i < FLUSH_DEPTH; i++) r_ring[i] <= r_ring[i-1];
        end
      end
    end
  end

  assign issue_fire = w_fire;
  assign issue_pipe = hd_pipe & {NUM_PIPES{w_fire}};
  assign sb_busy    = r_sb;
  assign idle       = (r_sb == '0) && !w_resv_any && (r_var_busy == '0);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stimulus pushes expected per-cycle
// outputs into a queue, a negedge monitor pops and compares them.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam logic [3:0] P_NOP = 4'b0000;
  localparam logic [3:0] P_ALU = 4'b0001;
  localparam logic [3:0] P_LSU = 4'b0010;
  localparam logic [3:0] P_MUL = 4'b0100;
  localparam logic [3:0] P_DIV = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hd_valid = 1'b0;
  logic [3:0]  hd_pipe = '0;
  logic [4:0]  hd_rd = '0, hd_rs1 = '0, hd_rs2 = '0;
  logic        hd_reg_write = 1'b0, hd_uses_rs1 = 1'b0, hd_uses_rs2 = 1'b0;
  logic        hold = 1'b0, flush = 1'b0, wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [3:0]  var_done = '0;

  logic        fire, fire_nb, idle, idle_nb;
  logic [3:0]  ipipe, ipipe_nb;
  logic [31:0] sb, sb_nb;

  always #5 clk = ~clk;

  issue_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .hd_valid(hd_valid), .hd_pipe(hd_pipe),
    .hd_rd(hd_rd), .hd_rs1(hd_rs1), .hd_rs2(hd_rs2), .hd_reg_write(hd_reg_write),
    .hd_uses_rs1(hd_uses_rs1), .hd_uses_rs2(hd_uses_rs2), .hold(hold), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .var_done(var_done),
    .issue_fire(fire), .issue_pipe(ipipe), .sb_busy(sb), .idle(idle)
  );

  issue_scoreboard #(.VAR_BLOCKING(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .hd_valid(hd_valid), .hd_pipe(hd_pipe),
    .hd_rd(hd_rd), .hd_rs1(hd_rs1), .hd_rs2(hd_rs2), .hd_reg_write(hd_reg_write),
    .hd_uses_rs1(hd_uses_rs1), .hd_uses_rs2(hd_uses_rs2), .hold(hold), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .var_done(var_done),
    .issue_fire(fire_nb), .issue_pipe(ipipe_nb), .sb_busy(sb_nb), .idle(idle_nb)
  );

  typedef struct {
    int          id;
    logic        fire;
    logic [3:0]  pipe;
    logic        fire_nb;
    logic [31:0] sb;
    logic        idle;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  function automatic logic [31:0] b(input int i);
    logic [31:0] one;
    one = 32'd1;
    return one << i;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fire",    e.id, {31'd0, fire},    {31'd0, e.fire});
        chk("pipe",    e.id, {28'd0, ipipe},   {28'd0, e.pipe});
        chk("fire_nb", e.id, {31'd0, fire_nb}, {31'd0, e.fire_nb});
        chk("sb_busy", e.id, sb,               e.sb);
        chk("idle",    e.id, {31'd0, idle},    {31'd0, e.idle});
      end
    end
  end

  task automatic head(input logic v, input logic [3:0] p, input int rd,
                      input int rs1, input logic u1, input int rs2, input logic u2,
                      input logic rw);
    hd_valid     = v;
    hd_pipe      = p;
    hd_rd        = 5'(rd);
    hd_rs1       = 5'(rs1);
    hd_uses_rs1  = u1;
    hd_rs2       = 5'(rs2);
    hd_uses_rs2  = u2;
    hd_reg_write = rw;
  endtask

  task automatic step(input logic ef, input logic efnb, input logic [31:0] esb, input logic eidle);
    exp_t e;
    e.id      = vec;
    e.fire    = ef;
    e.pipe    = ef ? hd_pipe : 4'b0000;
    e.fire_nb = efnb;
    e.sb      = esb;
    e.idle    = eidle;
    vec++;
    q.push_back(e);
    @(posedge clk);
    #1;
    hold     = 1'b0;
    flush    = 1'b0;
    wb_valid = 1'b0;
    var_done = '0;
  endtask

  task automatic do_reset();
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 32'd0, 1);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [31:0] m;
    @(posedge clk);
    #1;
    do_reset();

    // RAW on rs1, no WB bypass, then rs2 usage mask
    head(1, P_ALU, 5, 1, 0, 2, 0, 1);  step(1, 1, 32'd0, 1);
    head(1, P_ALU, 6, 5, 1, 0, 0, 1);  step(0, 0, b(5), 0);
    wb_valid = 1; wb_rd = 5'd5;         step(0, 0, b(5), 0);
                                        step(1, 1, 32'd0, 1);
    head(1, P_ALU, 7, 0, 0, 6, 1, 1);  step(0, 0, b(6), 0);
    head(1, P_ALU, 7, 0, 0, 6, 0, 1);  step(1, 1, b(6), 0);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);  step(0, 0, b(6) | b(7), 0);
    do_reset();

    // Hold blocks an otherwise clean head
    head(1, P_ALU, 1, 0, 0, 0, 0, 1); hold = 1; step(0, 0, 32'd0, 1);
    do_reset();

    // WB slot: LSU then ALU; MUL then LSU
    head(1, P_LSU, 3, 0, 0, 0, 0, 1);  step(1, 1, 32'd0, 1);
    head(1, P_ALU, 4, 0, 0, 0, 0, 1);  step(0, 0, b(3), 0);
                                        step(1, 1, b(3), 0);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0); wb_valid = 1; wb_rd = 5'd3; step(0, 0, b(3) | b(4), 0);
    wb_valid = 1; wb_rd = 5'd4;         step(0, 0, b(4), 0);
                                        step(0, 0, 32'd0, 1);
    head(1, P_MUL, 10, 0, 0, 0, 0, 1); step(1, 1, 32'd0, 1);
    head(1, P_LSU, 11, 0, 0, 0, 0, 1); step(0, 0, b(10), 0);
                                        step(1, 1, b(10), 0);
    do_reset();

    // Variable-latency blocking vs non-blocking instance
    head(1, P_DIV, 12, 0, 0, 0, 0, 1); step(1, 1, 32'd0, 1);
    head(1, P_ALU, 13, 0, 0, 0, 0, 1); step(0, 1, b(12), 0);
    var_done = P_DIV;                   step(0, 0, b(12), 0);
                                        step(1, 0, b(12), 0);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);  step(0, 0, b(12) | b(13), 0);
    do_reset();

    // Flush unwinds only the two youngest destinations
    head(1, P_ALU, 8, 0, 0, 0, 0, 1);  step(1, 1, 32'd0, 1);
    head(1, P_ALU, 9, 0, 0, 0, 0, 1);  step(1, 1, b(8), 0);
    head(1, P_LSU, 7, 0, 0, 0, 0, 1);  step(1, 1, b(8) | b(9), 0);
    head(1, P_ALU, 21, 0, 0, 0, 0, 1); flush = 1; step(0, 0, b(7) | b(8) | b(9), 0);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);  step(0, 0, b(8), 0);
    do_reset();

    // Flush clears an outstanding DIV
    head(1, P_DIV, 22, 0, 0, 0, 0, 1); step(1, 1, 32'd0, 1);
    head(1, P_ALU, 23, 0, 0, 0, 0, 1); flush = 1; step(0, 0, b(22), 0);
                                        step(1, 1, 32'd0, 1);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);  step(0, 0, b(23), 0);
    do_reset();

    // x0 is never tracked
    head(1, P_ALU, 0, 0, 1, 0, 1, 1);  step(1, 1, 32'd0, 1);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);  step(0, 0, 32'd0, 1);

    // Fill x1..x31, then a NOP with all-hazard operands fires at once
    m = 32'd0;
    for (int i = 1; i < 32; i++) begin
      head(1, P_ALU, i, 0, 0, 0, 0, 1);
      step(1, 1, m, (m == 32'd0));
      m = m | b(i);
    end
    head(1, P_NOP, 5, 5, 1, 5, 1, 1);  step(1, 1, 32'hFFFF_FFFE, 0);

    // Reset asserted mid-stall
    head(1, P_ALU, 6, 5, 1, 0, 0, 1);  step(0, 0, 32'hFFFF_FFFE, 0);
    do_reset();
    head(1, P_ALU, 6, 5, 1, 0, 0, 1);  step(1, 1, 32'd0, 1);
    head(0, P_NOP, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
